// File: rtl/jacobi_pkg.sv
// Shared types and defaults for the Jacobi input staging buffer.
// Holds the buffer state enum, the default matrix geometry and the
// sign-extension helper used on the replay path.
package jacobi_pkg;

  localparam int N              = 8;
  localparam int IN_WORD_WIDTH  = 16;
  localparam int OUT_WORD_WIDTH = 20;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } buf_state_t;

  // Widen a two's-complement input word by replicating its sign bit.
  function automatic logic [OUT_WORD_WIDTH-1:0] sext(input logic [IN_WORD_WIDTH-1:0] w);
    return {{(OUT_WORD_WIDTH-IN_WORD_WIDTH){w[IN_WORD_WIDTH-1]}}, w};
  endfunction

endpackage

// File: rtl/jacobi_idx_cnt.sv
// Row/column walker for the matrix buffer.
// Steps row-major over an N x N matrix. In triangular mode the column
// wraps to the new row index instead of 0, so only c >= r is visited.
// tc flags the final element (N-1, N-1). clr restarts at (0,0).
module jacobi_idx_cnt #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         tri_mode,
  output logic [W-1:0] r,
  output logic [W-1:0] c,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_reg, c_reg;
  logic [W-1:0] r_next, c_next;

  // Next position: wrap the column at N-1 and bump the row.
  always_comb begin
    r_next = r_reg;
    c_next = c_reg;
    if (c_reg == LAST) begin
      r_next = r_reg + W'(1);
      c_next = tri_mode ? (r_reg + W'(1)) : '0;
    end else begin
      c_next = c_reg + W'(1);
    end
  end

  // Position registers; reset and clear both return to (0,0).
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_reg <= '0;
      c_reg <= '0;
    end else if (en) begin
      r_reg <= r_next;
      c_reg <= c_next;
    end
  end

  assign r  = r_reg;
  assign c  = c_reg;
  assign tc = (r_reg == LAST) && (c_reg == LAST);

endmodule

// File: rtl/jacobi_matrix_buf.sv
// Input staging buffer for the Jacobi eigen-solver.
// Loads one N x N matrix (or its upper triangle, mirrored, when TRI_IN=1)
// from a valid/ready stream, then replays it row-major, sign-extended,
// with a last-beat marker. Load and drain alternate; one shared index
// walker serves both phases and restarts at every phase change.
// Optional feature macro: JACOBI_BUF_SYMCHK_EN adds a sticky symmetry
// check reported on sym_err_o.
module jacobi_matrix_buf #(
  parameter int N              = jacobi_pkg::N,
  parameter int IN_WORD_WIDTH  = jacobi_pkg::IN_WORD_WIDTH,
  parameter int OUT_WORD_WIDTH = jacobi_pkg::OUT_WORD_WIDTH,
  parameter int TRI_IN         = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WORD_WIDTH-1:0]  in_dat_i,
  input  logic                      in_vld_i,
  output logic                      in_rdy_o,
  output logic [OUT_WORD_WIDTH-1:0] out_dat_o,
  output logic                      out_vld_o,
  output logic                      out_last_o,
  input  logic                      out_rdy_i
`ifdef JACOBI_BUF_SYMCHK_EN
  ,
  output logic                      sym_err_o
`endif
);

  import jacobi_pkg::*;

  localparam int W = $clog2(N);

  buf_state_t state_reg, state_next;

  // Matrix storage: plain register array, deliberately not reset.
  logic [IN_WORD_WIDTH-1:0] mem [N][N];

  logic [W-1:0]             r, c;
  logic                     tc;
  logic                     load_fire, drain_fire;
  logic                     cnt_en, cnt_clr;
  logic                     tri_mode;
  logic [IN_WORD_WIDTH-1:0] rd_word;

  // Handshakes are qualified by rst so nothing moves while reset is held.
  assign load_fire  = rst && (state_reg == LOAD)  && in_vld_i;
  assign drain_fire = rst && (state_reg == DRAIN) && out_rdy_i;
  assign cnt_en     = load_fire || drain_fire;
  // Accepting the terminal element ends the phase and restarts the walker.
  assign cnt_clr    = cnt_en && tc;
  assign tri_mode   = (TRI_IN != 0) && (state_reg == LOAD);

  jacobi_idx_cnt #(
    .N (N),
    .W (W)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .tri_mode (tri_mode),
    .r        (r),
    .c        (c),
    .tc       (tc)
  );

  // Phase flips whenever the terminal element of the current phase transfers.
  always_comb begin
    state_next = state_reg;
    if (cnt_clr) begin
      state_next = (state_reg == LOAD) ? DRAIN : LOAD;
    end
  end

  // State register; reset lands in LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Store each accepted word; triangle input also fills the mirror slot.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[r][c] <= in_dat_i;
      if (TRI_IN != 0) begin
        mem[c][r] <= in_dat_i;
      end
    end
  end

  assign rd_word    = mem[r][c];
  assign in_rdy_o   = (state_reg == LOAD);
  assign out_vld_o  = (state_reg == DRAIN);
  assign out_last_o = out_vld_o && tc;

  generate
    if (IN_WORD_WIDTH == jacobi_pkg::IN_WORD_WIDTH &&
        OUT_WORD_WIDTH == jacobi_pkg::OUT_WORD_WIDTH) begin : g_sext_pkg
      assign out_dat_o = sext(rd_word);
    end else begin : g_sext_gen
      assign out_dat_o = OUT_WORD_WIDTH'($signed(rd_word));
    end
  endgenerate

`ifdef JACOBI_BUF_SYMCHK_EN
  logic sym_err_reg;

  // Sticky mismatch of mem[r][c] vs mem[c][r] over the drain; the final
  // beat is a diagonal element, so the flag is complete by then and is
  // cleared as the block returns to LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_err_reg <= 1'b0;
    end else if (drain_fire) begin
      if (tc) begin
        sym_err_reg <= 1'b0;
      end else if (mem[r][c] != mem[c][r]) begin
        sym_err_reg <= 1'b1;
      end
    end
  end

  assign sym_err_o = sym_err_reg;
`endif

endmodule

// File: tb/tb_jacobi_matrix_buf.sv
`timescale 1ns/1ps
module tb_jacobi_matrix_buf;

  localparam int IW  = 16;
  localparam int OW  = 20;
  localparam int FN  = 4;
  localparam int FNN = FN * FN;
  localparam int TN  = 3;
  localparam int TNN = TN * TN;
  localparam int TNT = TN * (TN + 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-matrix instance (N=4, TRI_IN=0)
  logic          f_rst;
  logic [IW-1:0] f_in_dat;
  logic          f_in_vld, f_in_rdy;
  logic [OW-1:0] f_out_dat;
  logic          f_out_vld, f_out_last, f_out_rdy;
  // Triangle instance (N=3, TRI_IN=1)
  logic          t_rst;
  logic [IW-1:0] t_in_dat;
  logic          t_in_vld, t_in_rdy;
  logic [OW-1:0] t_out_dat;
  logic          t_out_vld, t_out_last, t_out_rdy;
`ifdef JACOBI_BUF_SYMCHK_EN
  logic          f_sym_err, t_sym_err;
`endif

  jacobi_matrix_buf #(.N(FN), .IN_WORD_WIDTH(IW), .OUT_WORD_WIDTH(OW), .TRI_IN(0)) dut_full (
    .clk        (clk),
    .rst        (f_rst),
    .in_dat_i   (f_in_dat),
    .in_vld_i   (f_in_vld),
    .in_rdy_o   (f_in_rdy),
    .out_dat_o  (f_out_dat),
    .out_vld_o  (f_out_vld),
    .out_last_o (f_out_last),
    .out_rdy_i  (f_out_rdy)
`ifdef JACOBI_BUF_SYMCHK_EN
    ,
    .sym_err_o  (f_sym_err)
`endif
  );

  jacobi_matrix_buf #(.N(TN), .IN_WORD_WIDTH(IW), .OUT_WORD_WIDTH(OW), .TRI_IN(1)) dut_tri (
    .clk        (clk),
    .rst        (t_rst),
    .in_dat_i   (t_in_dat),
    .in_vld_i   (t_in_vld),
    .in_rdy_o   (t_in_rdy),
    .out_dat_o  (t_out_dat),
    .out_vld_o  (t_out_vld),
    .out_last_o (t_out_last),
    .out_rdy_i  (t_out_rdy)
`ifdef JACOBI_BUF_SYMCHK_EN
    ,
    .sym_err_o  (t_sym_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference sign extension from the word format definition.
  function automatic logic [OW-1:0] sx(input logic [IW-1:0] w);
    return {{(OW-IW){w[IW-1]}}, w};
  endfunction

  // Load a full 4x4 matrix, then drain it under a ready pattern
  // (0: always ready, 1: 1010..., 2: random). abort_at >= 0 resets after
  // that many drain beats.
  task automatic run_full(input logic [IW-1:0] w [FNN], input bit gaps,
                          input int rdy_mode, input int abort_at, input string name);
    logic [IW-1:0] m [FN][FN];
    logic [OW-1:0] exp_q [$];
    bit            exp_sym;
    bit            gap, rdy, prev_stall;
    logic [OW-1:0] prev_dat;
    logic          prev_last;
    int            k, idx, cyc;
    for (int i = 0; i < FN; i++)
      for (int j = 0; j < FN; j++)
        m[i][j] = w[i*FN + j];
    exp_sym = 1'b0;
    for (int i = 0; i < FN; i++)
      for (int j = 0; j < FN; j++) begin
        exp_q.push_back(sx(m[i][j]));
        if (m[i][j] != m[j][i]) exp_sym = 1'b1;
      end
    // load phase
    k = 0; cyc = 0;
    while (k < FNN && cyc < 400) begin
      @(posedge clk); #1;
      gap = gaps && ($urandom_range(0, 2) == 0);
      f_in_vld = !gap;
      f_in_dat = gap ? IW'($urandom) : w[k];
      @(negedge clk);
      check("ld_in_rdy", f_in_rdy, 1);
      check("ld_out_vld", f_out_vld, 0);
      if (!gap) k++;
      cyc++;
    end
    if (k < FNN) check("load_timeout", k, FNN);
    @(posedge clk); #1;
    f_in_vld = 1'b0;
    f_in_dat = '0;
    @(negedge clk);
    check("latency_vld", f_out_vld, 1);
    check("drain_in_rdy", f_in_rdy, 0);
    // drain phase
    idx = 0; cyc = 0; prev_stall = 1'b0; prev_dat = '0; prev_last = 1'b0;
    while (idx < FNN && cyc < 400 && idx != abort_at) begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      f_out_rdy = rdy;
      f_in_vld  = ($urandom_range(0, 1) == 1);
      f_in_dat  = IW'($urandom);
      @(negedge clk);
      check("dr_in_rdy", f_in_rdy, 0);
      check("dr_out_vld", f_out_vld, 1);
      if (prev_stall) begin
        check("hold_dat", f_out_dat, prev_dat);
        check("hold_last", f_out_last, prev_last);
      end
      if (rdy) begin
        check("dr_dat", f_out_dat, exp_q[idx]);
        check("dr_last", f_out_last, idx == FNN - 1);
`ifdef JACOBI_BUF_SYMCHK_EN
        if (idx == FNN - 1) check("sym_err", f_sym_err, exp_sym);
`endif
        idx++;
      end
      prev_stall = !rdy;
      prev_dat   = f_out_dat;
      prev_last  = f_out_last;
      cyc++;
    end
    if (abort_at >= 0 && idx == abort_at) begin
      @(posedge clk); #1;
      f_rst = 1'b0; f_out_rdy = 1'b0; f_in_vld = 1'b1; f_in_dat = IW'($urandom);
      @(posedge clk); #1;
      f_rst = 1'b1; f_in_vld = 1'b0;
      @(negedge clk);
      check("abort_out_vld", f_out_vld, 0);
      check("abort_in_rdy", f_in_rdy, 1);
      check("abort_last", f_out_last, 0);
      $display("matrix %s: aborted by reset after %0d drain beats", name, idx);
    end else begin
      if (idx < FNN) check("drain_timeout", idx, FNN);
      @(posedge clk); #1;
      f_out_rdy = 1'b0;
      f_in_vld  = 1'b0;
      @(negedge clk);
      check("post_in_rdy", f_in_rdy, 1);
      check("post_out_vld", f_out_vld, 0);
      $display("matrix %s: %0d beats drained, expected sym flag %0d", name, idx, exp_sym);
    end
  endtask

  // Partial load interrupted by reset; beats offered during reset must be ignored.
  task automatic abort_load(input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      @(posedge clk); #1;
      f_in_vld = 1'b1; f_in_dat = IW'($urandom);
    end
    @(posedge clk); #1;
    f_rst = 1'b0; f_in_vld = 1'b1; f_in_dat = IW'($urandom);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_rdy", f_in_rdy, 1);
    check("rst_out_vld", f_out_vld, 0);
    @(posedge clk); #1;
    f_rst = 1'b1; f_in_vld = 1'b0;
    $display("load aborted by reset after %0d beats", nbeats);
  endtask

  // Load the upper triangle of a 3x3 matrix and check the mirrored drain.
  task automatic run_tri(input logic [IW-1:0] w [TNT], input string name);
    logic [IW-1:0] m [TN][TN];
    logic [OW-1:0] exp_q [$];
    bit            rdy;
    int            k, idx, cyc;
    k = 0;
    for (int i = 0; i < TN; i++)
      for (int j = i; j < TN; j++) begin
        m[i][j] = w[k];
        m[j][i] = w[k];
        k++;
      end
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++)
        exp_q.push_back(sx(m[i][j]));
    for (int b = 0; b < TNT; b++) begin
      @(posedge clk); #1;
      t_in_vld = 1'b1; t_in_dat = w[b];
      @(negedge clk);
      check("tri_ld_rdy", t_in_rdy, 1);
      check("tri_ld_vld", t_out_vld, 0);
    end
    @(posedge clk); #1;
    t_in_vld = 1'b0;
    @(negedge clk);
    check("tri_latency", t_out_vld, 1);
    idx = 0; cyc = 0;
    while (idx < TNN && cyc < 200) begin
      @(posedge clk); #1;
      rdy = ($urandom_range(0, 2) != 0);
      t_out_rdy = rdy;
      @(negedge clk);
      check("tri_in_rdy", t_in_rdy, 0);
      if (rdy) begin
        check("tri_dat", t_out_dat, exp_q[idx]);
        check("tri_last", t_out_last, idx == TNN - 1);
`ifdef JACOBI_BUF_SYMCHK_EN
        if (idx == TNN - 1) check("tri_sym_err", t_sym_err, 0);
`endif
        idx++;
      end
      cyc++;
    end
    if (idx < TNN) check("tri_timeout", idx, TNN);
    @(posedge clk); #1;
    t_out_rdy = 1'b0;
    @(negedge clk);
    check("tri_post_rdy", t_in_rdy, 1);
    check("tri_post_vld", t_out_vld, 0);
    $display("triangle %s: %0d beats drained", name, idx);
  endtask

  logic [IW-1:0] wf [FNN];
  logic [IW-1:0] wt [TNT];

  initial begin
    f_rst = 1'b0; f_in_dat = '0; f_in_vld = 1'b0; f_out_rdy = 1'b0;
    t_rst = 1'b0; t_in_dat = '0; t_in_vld = 1'b0; t_out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    f_rst = 1'b1; t_rst = 1'b1;
    @(negedge clk);
    check("rst_f_in_rdy", f_in_rdy, 1);
    check("rst_f_out_vld", f_out_vld, 0);
    check("rst_f_out_last", f_out_last, 0);
    check("rst_t_in_rdy", t_in_rdy, 1);
    check("rst_t_out_vld", t_out_vld, 0);
`ifdef JACOBI_BUF_SYMCHK_EN
    check("rst_f_sym", f_sym_err, 0);
    check("rst_t_sym", t_sym_err, 0);
`endif

    // words 0..15 back-to-back, always ready
    for (int k = 0; k < FNN; k++) wf[k] = IW'(k);
    run_full(wf, 1'b0, 0, -1, "ramp");

    // sign-extension corners with input gaps and 1010 backpressure
    for (int k = 0; k < FNN; k++) wf[k] = IW'($urandom);
    wf[0] = 16'h8001; wf[1] = 16'h7FFF; wf[2] = 16'hFFFF; wf[3] = 16'h8000;
    run_full(wf, 1'b1, 1, -1, "sext_bp");

    // reset after 5 drain beats, then a clean matrix
    for (int k = 0; k < FNN; k++) wf[k] = IW'($urandom);
    run_full(wf, 1'b0, 1, 5, "abort_drain");
    for (int k = 0; k < FNN; k++) wf[k] = IW'($urandom);
    run_full(wf, 1'b1, 2, -1, "after_abort");

    // reset mid-load, then a symmetric matrix
    abort_load(6);
    for (int i = 0; i < FN; i++)
      for (int j = i; j < FN; j++) begin
        wf[i*FN + j] = IW'($urandom);
        wf[j*FN + i] = wf[i*FN + j];
      end
    run_full(wf, 1'b1, 2, -1, "symmetric");

    // triangle mode: 1..6 then random
    for (int k = 0; k < TNT; k++) wt[k] = IW'(k + 1);
    run_tri(wt, "ramp");
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < TNT; k++) wt[k] = IW'($urandom);
      run_tri(wt, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jacobi_matrix_buf.md
# jacobi_matrix_buf

Input staging buffer for the Jacobi eigen-solver. It accepts one symmetric N×N matrix as a valid/ready word stream and sign-extends each word from IN_WORD_WIDTH to OUT_WORD_WIDTH. It stores the full matrix in a register array, then replays it row-major with a last-beat marker to the downstream rotation engine. Load and drain alternate; input is back-pressured while draining.

## Interface
- N, 8, matrix dimension (≥2)
- IN_WORD_WIDTH, 16, input word width, two's complement
- OUT_WORD_WIDTH, 20, output word width (≥ IN_WORD_WIDTH)
- TRI_IN, 0, 0: input carries the full matrix (N·N words); 1: input carries the upper triangle only (N(N+1)/2 words), and the block mirrors it into the lower triangle
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- in_dat_i  in  IN_WORD_WIDTH  input word
- in_vld_i  in  1  input valid
- in_rdy_o  out  1  input ready
- out_dat_o  out  OUT_WORD_WIDTH  output word, sign-extended
- out_vld_o  out  1  output valid
- out_last_o  out  1  high on element (N-1,N-1) of the drain
- out_rdy_i  in  1  output ready
- sym_err_o  out  1  symmetry error; present only with the configuration macro (see Configuration)

## Operation
- States: LOAD, DRAIN. Reset state is LOAD.
- Row counter `r` and column counter `c` are each $clog2(N) bits wide. Both are cleared on reset and on every state change.
- LOAD:
  - in_rdy_o=1. A beat is transferred when in_vld_i && in_rdy_o.
  - TRI_IN=0: word → mem[r][c]. Order is row-major, c wraps N-1→0 and increments r.
  - TRI_IN=1: word → mem[r][c] and mem[c][r]. Order is row-major over c≥r, so c wraps to the new r, not to 0.
  - When the final element (r=N-1, c=N-1) is accepted, the block moves to DRAIN.
- DRAIN:
  - out_vld_o=1 and in_rdy_o=0.
  - out_dat_o = mem[r][c], row-major over the full N×N.
  - Counters advance only on out_vld_o && out_rdy_i.
  - out_last_o = (r=N-1 && c=N-1).
  - The last handshake returns the block to LOAD.
- Sign extension: replicate bit IN_WORD_WIDTH-1 into the upper OUT_WORD_WIDTH-IN_WORD_WIDTH bits.
- Matrix storage is not cleared by reset. Only the state, counters and flags reset.

## Timing
- Reset values: in_rdy_o=1, out_vld_o=0, out_last_o=0, sym_err_o=0. While rst=0, input beats are ignored and state is held.
- Latency: out_vld_o rises on the first cycle after the final input beat is accepted.
- Throughput: one word per cycle in each phase. A full matrix takes N·N load cycles (or N(N+1)/2 with TRI_IN=1) plus N·N drain cycles, with no bubble between phases.
- in_rdy_o and out_vld_o are never both high, so there is no simultaneous load/drain.
- out_dat_o, out_vld_o and out_last_o are held stable while out_vld_o=1 and out_rdy_i=0.
- in_vld_i may deassert mid-matrix; counters hold until the next beat.
- rst=0 mid-load or mid-drain aborts the matrix. The next cycle is LOAD at (0,0), and a partial drain is not completed.

## Configuration
- Macro `JACOBI_BUF_SYMCHK_EN`.
- Defined:
  - The sym_err_o port exists.
  - During DRAIN, each handshaked element compares mem[r][c] against mem[c][r]. Any mismatch sets a sticky flag.
  - sym_err_o equals the flag and is valid on the out_last_o beat.
  - The flag clears on entry to LOAD and on reset.
  - With TRI_IN=1 the comparison always passes, so sym_err_o stays 0.
- Undefined: the sym_err_o port and the compare logic are absent; all other behaviour is identical.

## Structure
- Package `jacobi_pkg` holds:
  - the state enum `buf_state_t` {LOAD, DRAIN}
  - the default constants N, IN_WORD_WIDTH, OUT_WORD_WIDTH
  - function `sext` (IN_WORD_WIDTH → OUT_WORD_WIDTH)
- One sub-module, `jacobi_idx_cnt`: row/column counter with enable, clear, a triangular-wrap mode input, and a terminal-count output. It is instantiated twice, once for load and once for drain, or shared.

## Test plan
- Full load, N=4, TRI_IN=0:
  - Stimulus: words 0..15 sent back-to-back, out_rdy_i=1.
  - Response: 16 output beats with values 0..15 in order, out_last_o only on beat 16, and out_vld_o rising the cycle after input beat 16.
- Sign extension, IN=16/OUT=20: input 0x8001 → output 0xF8001; input 0x7FFF → output 0x07FFF.
- Triangle mode, N=3, TRI_IN=1:
  - Stimulus: 1,2,3,4,5,6.
  - Response: drain order 1,2,3, 2,4,5, 3,5,6.
- Backpressure: out_rdy_i toggled 1010… during drain → data held stable while stalled, no beats lost or duplicated, and in_rdy_o=0 throughout the drain.
- Reset mid-drain: rst=0 after 5 drain beats → out_vld_o=0 on the next cycle, then in_rdy_o=1, and a new matrix loads from (0,0) and drains correctly.
- With JACOBI_BUF_SYMCHK_EN, N=2:
  - Input 1,2,3,4 → sym_err_o=1 at out_last_o.
  - Input 1,2,2,4 → sym_err_o=0.
